// File: rtl/bias_load_ctrl.sv
// Bias load sequencer: fetches per-column bias scalars from the unified
// buffer and strobes them one column at a time into the bias_child bank.
module bias_load_ctrl #(
   parameter int N_COLS = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int CNT_W  = $clog2(N_COLS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_cols,
   output logic              ub_rd_req,
   output logic [ADDR_W-1:0] ub_rd_addr,
   input  logic              ub_rd_valid,
   input  logic [DATA_W-1:0] ub_rd_data,
   input  logic              sys_busy,
   output logic [N_COLS-1:0] bias_load_en,
   output logic [DATA_W-1:0] bias_scalar_out,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_LOAD = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_col;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_base;
   logic [DATA_W-1:0] r_data;

   logic [CNT_W-1:0]  w_clamped;
   logic              w_last;
   logic              w_load_go;

   assign w_clamped = (num_cols > CNT_W'(N_COLS)) ? CNT_W'(N_COLS) : num_cols;
   assign w_last    = (r_col == r_count - CNT_W'(1));
   // A load may only fire while the array is quiet, so no bias moves mid-tile.
   assign w_load_go = (r_state == S_LOAD) && !sys_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_count <= '0;
         r_base  <= '0;
         r_data  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base  <= base_addr;
                  r_count <= w_clamped;
                  r_col   <= '0;
                  r_state <= (w_clamped == '0) ? S_DONE : S_REQ;
               end
            end
            S_REQ: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (ub_rd_valid) begin
                  r_data  <= ub_rd_data;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (!sys_busy) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_col   <= r_col + CNT_W'(1);
                     r_state <= S_REQ;
                  end
               end
            end
            S_DONE: begin
               r_col   <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      ub_rd_req  = (r_state == S_REQ);
      ub_rd_addr = '0;
      if (r_state == S_REQ) begin
         ub_rd_addr = r_base + ADDR_W'(r_col);
      end
   end

   always_comb begin
      bias_load_en = '0;
      for (int i = 0; i < N_COLS; i++) begin
         bias_load_en[i] = w_load_go && (r_col == CNT_W'(i));
      end
   end

   assign bias_scalar_out = r_data;
   assign busy            = (r_state != S_IDLE);
   assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Scoreboard bench for bias_load_ctrl: UB latency model, sys_busy stall
// windows, reset injection, expected reads/loads queued per scenario.
module tb_bias_load_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic [2:0]  num_cols;
   logic        ub_rd_req;
   logic [15:0] ub_rd_addr;
   logic        ub_rd_valid;
   logic [15:0] ub_rd_data;
   logic        sys_busy;
   logic [3:0]  bias_load_en;
   logic [15:0] bias_scalar_out;
   logic        busy;
   logic        done;

   bias_load_ctrl #(
      .N_COLS(4),
      .ADDR_W(16),
      .DATA_W(16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .base_addr       (base_addr),
      .num_cols        (num_cols),
      .ub_rd_req       (ub_rd_req),
      .ub_rd_addr      (ub_rd_addr),
      .ub_rd_valid     (ub_rd_valid),
      .ub_rd_data      (ub_rd_data),
      .sys_busy        (sys_busy),
      .bias_load_en    (bias_load_en),
      .bias_scalar_out (bias_scalar_out),
      .busy            (busy),
      .done            (done)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  en;
      logic [15:0] d;
   } load_t;

   typedef struct {
      int          due;
      logic [15:0] a;
   } rd_t;

   int n_chk;
   int n_fail;
   int cyc;
   int lat;
   int sb_lo, sb_hi;
   int rst_lo, rst_hi;
   int spur_cyc;

   rd_t         pend[$];
   logic [15:0] exp_addr[$];
   logic [15:0] obs_addr[$];
   load_t       exp_ld[$];
   load_t       obs_ld[$];
   int          obs_done[$];
   logic        busy_log[$];
   logic [15:0] scal_log[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time expired, want completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ub_mem(input logic [15:0] a);
      case (a)
         16'h0010: return 16'h0100;
         16'h0011: return 16'hFF00;
         16'h0012: return 16'h0080;
         16'h0013: return 16'h7FFF;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   task automatic clear();
      cyc      = 0;
      lat      = 1;
      sb_lo    = -1;
      sb_hi    = -2;
      rst_lo   = -1;
      rst_hi   = -2;
      spur_cyc = -1;
      pend.delete();
      exp_addr.delete();
      obs_addr.delete();
      exp_ld.delete();
      obs_ld.delete();
      obs_done.delete();
      busy_log.delete();
      scal_log.delete();
   endtask

   // One clock cycle: drive inputs at negedge, answer UB reads, log outputs.
   task automatic tick(input logic st, input logic [15:0] ba,
                       input logic [2:0] nc);
      rd_t   r;
      load_t l;
      @(negedge clk);
      start       = st;
      base_addr   = ba;
      num_cols    = nc;
      rst         = (cyc >= rst_lo) && (cyc <= rst_hi);
      sys_busy    = (cyc >= sb_lo) && (cyc <= sb_hi);
      ub_rd_valid = 1'b0;
      ub_rd_data  = 16'h0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         ub_rd_valid = 1'b1;
         ub_rd_data  = ub_mem(pend[0].a);
         void'(pend.pop_front());
      end else if (cyc == spur_cyc) begin
         ub_rd_valid = 1'b1;
         ub_rd_data  = 16'hDEAD;
      end
      #1;
      if (ub_rd_req === 1'b1) begin
         obs_addr.push_back(ub_rd_addr);
         r.due = cyc + lat;
         r.a   = ub_rd_addr;
         pend.push_back(r);
      end
      if (bias_load_en !== 4'b0000) begin
         l.cyc = cyc;
         l.en  = bias_load_en;
         l.d   = bias_scalar_out;
         obs_ld.push_back(l);
      end
      if (done === 1'b1) obs_done.push_back(cyc);
      busy_log.push_back(busy);
      scal_log.push_back(bias_scalar_out);
      cyc++;
   endtask

   task automatic run(input logic [15:0] ba, input logic [2:0] nc,
                      input int n);
      tick(1'b1, ba, nc);
      repeat (n) tick(1'b0, ba, nc);
   endtask

   task automatic push_ld(input int c, input logic [3:0] en,
                          input logic [15:0] d);
      load_t l;
      l.cyc = c;
      l.en  = en;
      l.d   = d;
      exp_ld.push_back(l);
   endtask

   task automatic push_basic(input int shift);
      for (int i = 0; i < 4; i++) exp_addr.push_back(16'h0010 + 16'(i));
      push_ld(3 + shift, 4'b0001, 16'h0100);
      push_ld(6 + shift, 4'b0010, 16'hFF00);
      push_ld(9 + shift, 4'b0100, 16'h0080);
      push_ld(12 + shift, 4'b1000, 16'h7FFF);
   endtask

   task automatic test_reset();
      clear();
      rst_lo = 0;
      rst_hi = 1;
      tick(1'b0, 16'h0, 3'd0);
      tick(1'b0, 16'h0, 3'd0);
      tick(1'b0, 16'h0, 3'd0);
      n_chk++;
      if (ub_rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req: got %b want 0", ub_rd_req);
      end
      n_chk++;
      if (ub_rd_addr !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h want 0000", ub_rd_addr);
      end
      n_chk++;
      if (bias_load_en !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_en: got %b want 0000", bias_load_en);
      end
      n_chk++;
      if (bias_scalar_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_scalar: got %h want 0000", bias_scalar_out);
      end
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [15:0] e, o;
      load_t el, ol;
      clear();
      push_basic(0);
      run(16'h0010, 3'd4, 16);
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front();
         o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 16'hxxxx;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL basic_addr: got %h want %h", o, e);
         end
      end
      while (exp_ld.size() > 0) begin
         el = exp_ld.pop_front();
         ol.cyc = -1; ol.en = 4'hx; ol.d = 16'hxxxx;
         if (obs_ld.size() > 0) ol = obs_ld.pop_front();
         n_chk++;
         if (ol.cyc != el.cyc || ol.en !== el.en || ol.d !== el.d) begin
            n_fail++;
            $display("FAIL basic_load: got c%0d %b %h want c%0d %b %h",
                     ol.cyc, ol.en, ol.d, el.cyc, el.en, el.d);
         end
      end
      n_chk++;
      if (obs_addr.size() != 0 || obs_ld.size() != 0) begin
         n_fail++;
         $display("FAIL basic_extra: got %0d reads %0d loads want 0 0",
                  obs_addr.size(), obs_ld.size());
      end
      n_chk++;
      if (obs_done.size() != 1 || obs_done[0] != 13) begin
         n_fail++;
         $display("FAIL basic_done: got %0d pulses first c%0d want 1 at c13",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
      end
      for (int i = 0; i <= 14; i++) begin
         n_chk++;
         if (busy_log[i] !== ((i >= 1) && (i <= 13))) begin
            n_fail++;
            $display("FAIL basic_busy c%0d: got %b", i, busy_log[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] e, o;
      load_t el, ol;
      clear();
      sb_lo = 3;
      sb_hi = 7;
      push_basic(5);
      run(16'h0010, 3'd4, 21);
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front();
         o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 16'hxxxx;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall_addr: got %h want %h", o, e);
         end
      end
      while (exp_ld.size() > 0) begin
         el = exp_ld.pop_front();
         ol.cyc = -1; ol.en = 4'hx; ol.d = 16'hxxxx;
         if (obs_ld.size() > 0) ol = obs_ld.pop_front();
         n_chk++;
         if (ol.cyc != el.cyc || ol.en !== el.en || ol.d !== el.d) begin
            n_fail++;
            $display("FAIL stall_load: got c%0d %b %h want c%0d %b %h",
                     ol.cyc, ol.en, ol.d, el.cyc, el.en, el.d);
         end
      end
      for (int i = 3; i <= 7; i++) begin
         n_chk++;
         if (scal_log[i] !== 16'h0100) begin
            n_fail++;
            $display("FAIL stall_scalar c%0d: got %h want 0100", i, scal_log[i]);
         end
      end
      n_chk++;
      if (obs_done.size() != 1 || obs_done[0] != 18 || obs_ld.size() != 0) begin
         n_fail++;
         $display("FAIL stall_done: got %0d pulses first c%0d want 1 at c18",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] e, o;
      load_t el, ol;
      clear();
      lat = 4;
      exp_addr.push_back(16'hFFFF);
      exp_addr.push_back(16'h0000);
      push_ld(6, 4'b0001, 16'hA5A5);
      push_ld(12, 4'b0010, 16'h5A5A);
      run(16'hFFFF, 3'd2, 16);
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front();
         o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 16'hxxxx;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h want %h", o, e);
         end
      end
      while (exp_ld.size() > 0) begin
         el = exp_ld.pop_front();
         ol.cyc = -1; ol.en = 4'hx; ol.d = 16'hxxxx;
         if (obs_ld.size() > 0) ol = obs_ld.pop_front();
         n_chk++;
         if (ol.cyc != el.cyc || ol.en !== el.en || ol.d !== el.d) begin
            n_fail++;
            $display("FAIL wrap_load: got c%0d %b %h want c%0d %b %h",
                     ol.cyc, ol.en, ol.d, el.cyc, el.en, el.d);
         end
      end
      n_chk++;
      if (obs_done.size() != 1 || obs_done[0] != 13 || obs_ld.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_done: got %0d pulses extra_loads %0d want 1 at c13 0",
                  obs_done.size(), obs_ld.size());
      end
   endtask

   task automatic test_zero_clamp();
      clear();
      run(16'h0010, 3'd0, 5);
      n_chk++;
      if (obs_done.size() != 1 || obs_done[0] < 1 || obs_done[0] > 2) begin
         n_fail++;
         $display("FAIL zero_done: got %0d pulses first c%0d want 1 within 2",
                  obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
      end
      n_chk++;
      if (obs_addr.size() != 0 || obs_ld.size() != 0) begin
         n_fail++;
         $display("FAIL zero_activity: got %0d reads %0d loads want 0 0",
                  obs_addr.size(), obs_ld.size());
      end
      clear();
      run(16'h0010, 3'd7, 16);
      n_chk++;
      if (obs_addr.size() != 4 || obs_ld.size() != 4) begin
         n_fail++;
         $display("FAIL clamp_count: got %0d reads %0d loads want 4 4",
                  obs_addr.size(), obs_ld.size());
      end
      n_chk++;
      if (obs_ld.size() == 4 && (obs_ld[3].en !== 4'b1000 || obs_ld[3].cyc != 12)) begin
         n_fail++;
         $display("FAIL clamp_last: got c%0d %b want c12 1000",
                  obs_ld[3].cyc, obs_ld[3].en);
      end
      n_chk++;
      if (obs_done.size() != 1 || obs_done[0] != 13) begin
         n_fail++;
         $display("FAIL clamp_done: got %0d pulses want 1 at c13", obs_done.size());
      end
   endtask

   task automatic test_ignore();
      logic [15:0] e, o;
      load_t el, ol;
      clear();
      spur_cyc = 3;
      push_basic(0);
      tick(1'b1, 16'h0010, 3'd4);
      tick(1'b0, 16'h0010, 3'd4);
      tick(1'b1, 16'h0040, 3'd4);
      repeat (10) tick(1'b0, 16'h0040, 3'd4);
      tick(1'b1, 16'h0040, 3'd4);
      repeat (6) tick(1'b0, 16'h0040, 3'd4);
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front();
         o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 16'hxxxx;
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL ignore_addr: got %h want %h", o, e);
         end
      end
      while (exp_ld.size() > 0) begin
         el = exp_ld.pop_front();
         ol.cyc = -1; ol.en = 4'hx; ol.d = 16'hxxxx;
         if (obs_ld.size() > 0) ol = obs_ld.pop_front();
         n_chk++;
         if (ol.cyc != el.cyc || ol.en !== el.en || ol.d !== el.d) begin
            n_fail++;
            $display("FAIL ignore_load: got c%0d %b %h want c%0d %b %h",
                     ol.cyc, ol.en, ol.d, el.cyc, el.en, el.d);
         end
      end
      n_chk++;
      if (obs_addr.size() != 0 || obs_ld.size() != 0 || obs_done.size() != 1) begin
         n_fail++;
         $display("FAIL ignore_extra: got %0d reads %0d loads %0d dones want 0 0 1",
                  obs_addr.size(), obs_ld.size(), obs_done.size());
      end
   endtask

   task automatic test_reset_mid();
      clear();
      rst_lo = 5;
      rst_hi = 5;
      run(16'h0010, 3'd4, 5);
      tick(1'b0, 16'h0010, 3'd4);
      n_chk++;
      if ({ub_rd_req, ub_rd_addr, bias_load_en, bias_scalar_out, busy, done}
          !== '0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got req%b a%h en%b s%h b%b d%b want all 0",
                  ub_rd_req, ub_rd_addr, bias_load_en, bias_scalar_out, busy, done);
      end
      repeat (6) tick(1'b0, 16'h0010, 3'd4);
      n_chk++;
      if (obs_addr.size() != 2 || obs_ld.size() != 1 || obs_done.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid_abandon: got %0d reads %0d loads %0d dones want 2 1 0",
                  obs_addr.size(), obs_ld.size(), obs_done.size());
      end
      clear();
      run(16'h0010, 3'd4, 5);
      n_chk++;
      if (obs_addr.size() < 1 || obs_addr[0] !== 16'h0010) begin
         n_fail++;
         $display("FAIL restart_addr: got %0d reads first %h want 0010",
                  obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 16'hxxxx);
      end
      n_chk++;
      if (obs_ld.size() < 1 || obs_ld[0].cyc != 3 || obs_ld[0].en !== 4'b0001
          || obs_ld[0].d !== 16'h0100) begin
         n_fail++;
         $display("FAIL restart_load: got %0d loads want c3 0001 0100",
                  obs_ld.size());
      end
      repeat (12) tick(1'b0, 16'h0010, 3'd4);
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      base_addr   = 16'h0;
      num_cols    = 3'd0;
      ub_rd_valid = 1'b0;
      ub_rd_data  = 16'h0;
      sys_busy    = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_zero_clamp();
      test_ignore();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
